// File: rtl/relu_maxpool2x2_stream.sv
// ReLU followed by 2x2 / stride-2 max pooling on a row-major FP32 pixel stream.
// Comparisons are unsigned on the magnitude bits because every operand is >= +0 after ReLU.
module relu_maxpool2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

  generate
    if (WIDTH % 2 != 0) begin : g_bad_width
      $error("relu_maxpool2x2_stream: WIDTH must be even");
    end
    if (HEIGHT % 2 != 0) begin : g_bad_height
      $error("relu_maxpool2x2_stream: HEIGHT must be even");
    end
  endgenerate

  function automatic logic [DATA_WIDTH-1:0] pos_max(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
  endfunction

  logic [CW-1:0]         col_reg;
  logic [RW-1:0]         row_reg;
  logic [DATA_WIDTH-1:0] pair_reg;
  logic [DATA_WIDTH-1:0] lb_rd_reg;
  logic [DATA_WIDTH-1:0] linebuf [WIDTH/2];

  logic [DATA_WIDTH-1:0] relu_val;
  logic [DATA_WIDTH-1:0] hmax;
  logic [PW-1:0]         pool_col;
  logic                  col_odd;
  logic                  row_odd;
  logic                  col_last;
  logic                  row_last;
  logic                  beat;

  assign relu_val = data_in[DATA_WIDTH-1] ? '0 : data_in;
  assign hmax     = pos_max(pair_reg, relu_val);
  assign pool_col = PW'(col_reg >> 1);
  assign col_odd  = col_reg[0];
  assign row_odd  = row_reg[0];
  assign col_last = (col_reg == CW'(WIDTH - 1));
  assign row_last = (row_reg == RW'(HEIGHT - 1));
  assign beat     = valid_in && !rst;

  // The upper-row partial max is fetched on the even-column beat so the read is registered
  // and ready when the odd-column beat completes the 2x2 window.
  always_ff @(posedge clk) begin
    if (beat) begin
      if (col_odd && !row_odd) begin
        linebuf[pool_col] <= hmax;
      end
      if (!col_odd && row_odd) begin
        lb_rd_reg <= linebuf[pool_col];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg    <= '0;
      row_reg    <= '0;
      pair_reg   <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (!col_odd) begin
          pair_reg <= relu_val;
        end else if (row_odd) begin
          data_out   <= pos_max(lb_rd_reg, hmax);
          valid_out  <= 1'b1;
          frame_done <= row_last && col_last;
        end
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

endmodule
